// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iterative
//  Purpose  : Iterative RV32M multiply/divide unit for the EX stage.
//             Radix-2 shift/add multiplier and restoring divider sharing one
//             64-bit accumulator; 32 iterations per operation, with the
//             divide-by-zero and signed-overflow cases resolved in one cycle.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             start         - request, accepted only in IDLE without flush
//             flush         - abort current operation (branch/trap)
//             funct3        - M-extension operation select
//             op_a, op_b    - forwarded rs1/rs2, sampled with start
//             busy          - unit is not IDLE
//             stall         - holds IF/ID/EX while a request is in flight
//             done          - one-cycle result-valid pulse
//             result        - registered result, held until next accept
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [4:0]      cnt_q;
  logic [W2-1:0]   acc_q;     // mul: {product_hi, multiplier}; div: {rem, quot}
  logic [XLEN-1:0] b_q;       // multiplicand or divisor magnitude
  logic [2:0]      f3_q;
  logic            sa_q, sb_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  // Request decode
  logic            is_div, signed_a, signed_b, sa_in, sb_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  // Iteration datapath
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_next;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] trial;
  logic [W2-1:0]   div_next;
  logic [W2-1:0]   acc_d;

  // Sign fix-up of the final iteration
  logic            neg;
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] quot, rem, calc_res;

  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) |
               (funct3 == 3'b100) | (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    sa_in    = signed_a & op_a[XLEN-1];
    sb_in    = signed_b & op_b[XLEN-1];
    mag_a    = sa_in ? -op_a : op_a;
    mag_b    = sb_in ? -op_b : op_b;

    div_zero = is_div & (op_b == '0);
    // Only the signed forms (funct3[0] == 0) can overflow.
    div_ovf  = is_div & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) &
               (op_b == '1);
    special  = div_zero | div_ovf;

    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else if (div_ovf) begin
      special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Shift/add: add multiplicand into the high half, then shift the
    // 65-bit {carry, acc} right by one.
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : '0)};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring division: the shifted remainder can reach XLEN+1 bits, but
    // whenever it is >= divisor the difference fits in XLEN bits.
    rem_sh   = acc_q[W2-1:XLEN-1];
    trial    = rem_sh[XLEN-1:0] - b_q;
    if (rem_sh >= {1'b0, b_q}) begin
      div_next = {trial, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {acc_q[W2-2:0], 1'b0};
    end

    acc_d    = f3_q[2] ? div_next : mul_next;

    neg      = sa_q ^ sb_q;
    prod     = neg ? -acc_d : acc_d;
    quot     = neg  ? -acc_d[XLEN-1:0]  : acc_d[XLEN-1:0];
    rem      = sa_q ? -acc_d[W2-1:XLEN] : acc_d[W2-1:XLEN];
    if (f3_q[2]) begin
      calc_res = f3_q[1] ? rem : quot;
    end else begin
      calc_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            f3_q   <= funct3;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              b_q     <= is_div ? mag_b : mag_a;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= calc_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall  = ((state_q == S_IDLE) & start & ~flush) | (state_q == S_CALC);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
